uart_reg_arbiter: RTL

- Shares the UART register-select path (3-bit address to 8 one-hot register strobes) between two bus requesters: A, the host processor port, and B, the baud/config loader.
- Arbitrates round-robin and latches the winner's address, direction and write data.
- Issues a single-cycle one-hot write or read strobe, waits optional wait states, captures read data, and completes a 4-phase req/ack handshake.
- Sits between the requesters and the UART register file (TX holding, RX buffer, baud divisor, control, status).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_pick2.sv | 17 +
 rtl/uart_reg_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and register map for the UART register path.
package uart_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] TXD     = 3'd0;
  localparam logic [ADDR_W-1:0] RXD     = 3'd1;
  localparam logic [ADDR_W-1:0] BAUD_LO = 3'd2;
  localparam logic [ADDR_W-1:0] BAUD_HI = 3'd3;
  localparam logic [ADDR_W-1:0] CTRL    = 3'd4;
  localparam logic [ADDR_W-1:0] STAT    = 3'd5;

endpackage

// File: rtl/uart_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side that did not win last.
module uart_rr_pick2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last,   // 1 = B won most recently
  output logic [1:0] win     // {B, A}, at most one bit set
);

  // Pure combinational choice; last only matters on a tie.
  always_comb begin
    win = {req_b, req_a};
    if (req_a && req_b) begin
      win = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_reg_arbiter.sv
// Arbitrates two requesters onto the UART register strobes with a 4-phase req/ack handshake.
module uart_reg_arbiter
  import uart_pkg::state_t;
  import uart_pkg::IDLE;
  import uart_pkg::STROBE;
  import uart_pkg::WAIT;
  import uart_pkg::DONE;
#(
  parameter int ADDR_W   = uart_pkg::ADDR_W,
  parameter int DATA_W   = uart_pkg::DATA_W,
  parameter int WAIT_CYC = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_a,
  input  logic                   we_a,
  input  logic [ADDR_W-1:0]      addr_a,
  input  logic [DATA_W-1:0]      wdata_a,
  output logic                   ack_a,
  input  logic                   req_b,
  input  logic                   we_b,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [DATA_W-1:0]      wdata_b,
  output logic                   ack_b,
  output logic [2**ADDR_W-1:0]   wr_stb,
  output logic [2**ADDR_W-1:0]   rd_stb,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic [DATA_W-1:0]      rdata_in,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             gnt,
  output logic                   busy
);

  localparam int NREG   = 2 ** ADDR_W;
  localparam int WCNT_W = 4;

  state_t              state, state_d;
  logic                last, last_d;
  logic                we_q, we_d;
  logic [WCNT_W-1:0]   wcnt, wcnt_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic [NREG-1:0]     wr_stb_d, rd_stb_d;
  logic [1:0]          gnt_d;
  logic                ack_a_d, ack_b_d;
  logic [1:0]          win;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                owner_req;

  uart_rr_pick2 u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last),
    .win   (win)
  );

  assign busy = (state != IDLE);

  // Next-state and next-output logic; strobes default low so they last one cycle.
  // The address is not kept separately: the registered strobe itself carries it.
  always_comb begin
    state_d   = state;
    last_d    = last;
    we_d      = we_q;
    wcnt_d    = wcnt;
    wdata_d   = bus_wdata;
    rdata_d   = rdata;
    gnt_d     = gnt;
    ack_a_d   = ack_a;
    ack_b_d   = ack_b;
    wr_stb_d  = '0;
    rd_stb_d  = '0;
    sel_we    = win[1] ? we_b    : we_a;
    sel_addr  = win[1] ? addr_b  : addr_a;
    sel_wdata = win[1] ? wdata_b : wdata_a;
    owner_req = gnt[1] ? req_b   : req_a;

    unique case (state)
      IDLE: begin
        if (|win) begin
          we_d    = sel_we;
          wdata_d = sel_wdata;
          gnt_d   = win;
          last_d  = win[1];
          if (sel_we) begin
            wr_stb_d = NREG'(1) << sel_addr;
          end else begin
            rd_stb_d = NREG'(1) << sel_addr;
          end
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (WAIT_CYC == 0) begin
          if (!we_q) begin
            rdata_d = rdata_in;
          end
          ack_a_d = gnt[0];
          ack_b_d = gnt[1];
          state_d = DONE;
        end else begin
          wcnt_d  = WCNT_W'(WAIT_CYC);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt <= WCNT_W'(1)) begin
          if (!we_q) begin
            rdata_d = rdata_in;
          end
          wcnt_d  = '0;
          ack_a_d = gnt[0];
          ack_b_d = gnt[1];
          state_d = DONE;
        end else begin
          wcnt_d = wcnt - WCNT_W'(1);
        end
      end
      DONE: begin
        if (!owner_req) begin
          ack_a_d = 1'b0;
          ack_b_d = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and all outputs registered; reset cancels any in-flight strobe at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      we_q      <= 1'b0;
      wcnt      <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      gnt       <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      wr_stb    <= '0;
      rd_stb    <= '0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      we_q      <= we_d;
      wcnt      <= wcnt_d;
      bus_wdata <= wdata_d;
      rdata     <= rdata_d;
      gnt       <= gnt_d;
      ack_a     <= ack_a_d;
      ack_b     <= ack_b_d;
      wr_stb    <= wr_stb_d;
      rd_stb    <= rd_stb_d;
    end
  end

endmodule
